// File: rtl/mem_access_seq.sv
// -----------------------------------------------------------------------------
// mem_access_seq
//
// Load/store initiator that sits between the CPU datapath and a byte-wide,
// single-port data RAM. A request (BYTE, HALF, WORD, WORDL, WORDR) is taken
// over a valid/ready handshake. It is then issued as one RAM byte access per
// cycle. Load bytes are assembled into a word, with sign/zero extension or an
// LWL/LWR merge with rt. Completion is reported with a one-cycle resp_valid.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   req_valid/ready   request handshake; ready only while idle
//   req_write         1 = store, 0 = load
//   req_addr          byte address (ADDR_W bits, wraps)
//   req_type          0 BYTE, 1 HALF, 2 WORD, 3 WORDL, 4 WORDR, 5..7 no-op
//   req_unsigned      zero-extend (1) / sign-extend (0) BYTE/HALF loads
//   req_wdata         store data
//   req_rt            rt value merged into LWL/LWR results
//   resp_valid        one-cycle completion pulse
//   resp_rdata        load result; holds until the next load response
//   mem_addr/re/we    RAM byte address, read strobe, write strobe
//   mem_wdata         RAM write byte
//   mem_rdata         RAM read byte, valid the cycle after mem_re
// -----------------------------------------------------------------------------
module mem_access_seq #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [2:0]        req_type,
  input  logic              req_unsigned,
  input  logic [31:0]       req_wdata,
  input  logic [31:0]       req_rt,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_re,
  output logic              mem_we,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_XFER = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_RESP = 2'd3;

  localparam logic [2:0] T_BYTE  = 3'd0;
  localparam logic [2:0] T_HALF  = 3'd1;
  localparam logic [2:0] T_WORD  = 3'd2;
  localparam logic [2:0] T_WORDL = 3'd3;
  localparam logic [2:0] T_WORDR = 3'd4;

  logic [1:0]        state_q, state_d;
  logic              write_q, write_d;
  logic [2:0]        type_q, type_d;
  logic              unsigned_q, unsigned_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       data_q, data_d;       // load bytes assembled in place
  logic [1:0]        idx_q, idx_d;         // index of the byte being issued
  logic [1:0]        cap_q, cap_d;         // index of the next byte to capture
  logic [1:0]        last_q, last_d;       // N-1
  logic [1:0]        shift_q, shift_d;     // byte lane offset (a for WORDL)
  logic              rd_pend_q, rd_pend_d; // a read was issued last cycle
  logic [31:0]       rdata_q, rdata_d;

  logic              accept;
  logic [1:0]        wr_lane;
  logic [1:0]        cap_lane;
  logic [31:0]       load_result;
  logic [1:0]        req_a;

  assign req_a      = req_addr[1:0];
  assign accept     = req_valid && req_ready;

  assign req_ready  = (state_q == S_IDLE);
  assign resp_valid = (state_q == S_RESP);
  assign resp_rdata = rdata_q;
  assign mem_re     = (state_q == S_XFER) && !write_q;
  assign mem_we     = (state_q == S_XFER) &&  write_q;
  assign mem_addr   = base_q + ADDR_W'(idx_q);

  // SWL takes store bytes from lane a upward; every other store starts at lane 0.
  assign wr_lane    = idx_q + shift_q;
  assign mem_wdata  = wdata_q[8*wr_lane +: 8];

  // LWL places captured bytes from lane a upward; everything else from lane 0.
  assign cap_lane   = cap_q + shift_q;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    state_d    = state_q;
    write_d    = write_q;
    type_d     = type_q;
    unsigned_d = unsigned_q;
    base_d     = base_q;
    wdata_d    = wdata_q;
    data_d     = data_q;
    idx_d      = idx_q;
    cap_d      = cap_q;
    last_d     = last_q;
    shift_d    = shift_q;
    rdata_d    = rdata_q;
    rd_pend_d  = mem_re;

    // Read data arrives one cycle after its strobe, so capture follows issue.
    if (rd_pend_q) begin
      data_d[8*cap_lane +: 8] = mem_rdata;
      cap_d                   = cap_q + 2'd1;
    end

    // Extension uses data_d so the byte captured in WAIT is included.
    case (type_q)
      T_BYTE:  load_result = unsigned_q ? {24'h0, data_d[7:0]}
                                        : {{24{data_d[7]}}, data_d[7:0]};
      T_HALF:  load_result = unsigned_q ? {16'h0, data_d[15:0]}
                                        : {{16{data_d[15]}}, data_d[15:0]};
      default: load_result = data_d;
    endcase

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          write_d    = req_write;
          type_d     = req_type;
          unsigned_d = req_unsigned;
          base_d     = req_addr;
          wdata_d    = req_wdata;
          idx_d      = 2'd0;
          cap_d      = 2'd0;
          shift_d    = (req_type == T_WORDL) ? req_a : 2'd0;
          // LWL/LWR keep rt in the lanes the RAM bytes do not overwrite.
          data_d     = (req_type == T_WORDL || req_type == T_WORDR) ? req_rt : 32'h0;
          case (req_type)
            T_BYTE:  last_d = 2'd0;
            T_HALF:  last_d = 2'd1;
            T_WORD:  last_d = 2'd3;
            T_WORDL: last_d = 2'd3 - req_a;
            T_WORDR: last_d = req_a;
            default: last_d = 2'd0;
          endcase
          if (req_type > T_WORDR) begin
            // Unsupported type: no RAM traffic, respond immediately.
            state_d = S_RESP;
            if (!req_write) rdata_d = 32'h0;
          end else begin
            state_d = S_XFER;
          end
        end
      end
      S_XFER: begin
        if (idx_q == last_q) begin
          state_d = write_q ? S_RESP : S_WAIT;
        end else begin
          idx_d = idx_q + 2'd1;
        end
      end
      S_WAIT: begin
        state_d = S_RESP;
        rdata_d = load_result;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its pre-edge value regardless of statement order.
    if (rst) begin
      state_q    <= S_IDLE;
      write_q    <= 1'b0;
      type_q     <= T_BYTE;
      unsigned_q <= 1'b0;
      base_q     <= '0;
      wdata_q    <= 32'h0;
      data_q     <= 32'h0;
      idx_q      <= 2'd0;
      cap_q      <= 2'd0;
      last_q     <= 2'd0;
      shift_q    <= 2'd0;
      rd_pend_q  <= 1'b0;
      rdata_q    <= 32'h0;
    end else begin
      state_q    <= state_d;
      write_q    <= write_d;
      type_q     <= type_d;
      unsigned_q <= unsigned_d;
      base_q     <= base_d;
      wdata_q    <= wdata_d;
      data_q     <= data_d;
      idx_q      <= idx_d;
      cap_q      <= cap_d;
      last_q     <= last_d;
      shift_q    <= shift_d;
      rd_pend_q  <= rd_pend_d;
      rdata_q    <= rdata_d;
    end
  end

endmodule

// File: doc/mem_access_seq.md
Name: mem_access_seq

Overview:
- Load/store initiator between the CPU datapath and a byte-wide, single-port data RAM.
- Accepts one word, half, byte, LWL/LWR or SWL/SWR request over a valid/ready handshake.
- Serialises the request into one byte access per cycle, assembles load results with extension or partial-word merge, and returns a single response pulse.
- Adds SWL/SWR partial-word stores, mirroring the LWL/LWR load semantics.

Parameters:
ADDR_W, 10, byte address width; all address arithmetic wraps modulo 2^ADDR_W.

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
req_valid  in  1  request present
req_ready  out  1  block can accept a request
req_write  in  1  1 = store, 0 = load
req_addr  in  ADDR_W  byte address
req_type  in  3  data type: 0 BYTE, 1 HALF, 2 WORD, 3 WORDL, 4 WORDR
req_unsigned  in  1  1 = zero-extend, 0 = sign-extend (BYTE/HALF loads only)
req_wdata  in  32  store data
req_rt  in  32  current rt value, merged into LWL/LWR results
resp_valid  out  1  one-cycle completion pulse
resp_rdata  out  32  load result; holds until the next load response
mem_addr  out  ADDR_W  RAM byte address
mem_re  out  1  RAM byte read; mem_rdata is valid on the following cycle
mem_we  out  1  RAM byte write
mem_wdata  out  8  RAM write byte
mem_rdata  in  8  RAM read byte

Behaviour:
- Reset state: IDLE. req_ready=1; resp_valid, mem_re, mem_we=0; mem_addr, mem_wdata, resp_rdata=0.
- Reset mid-operation aborts the transfer. No resp_valid is produced for the aborted request. Bytes already written stay written.
- Accept: the request is captured on the edge where req_valid && req_ready. All req_* inputs are ignored while busy.
- req_ready=1 only in IDLE.
- States:
  - IDLE -> XFER on accept.
  - XFER issues bytes; goes to WAIT after the last byte if the op is a load, else to RESP.
  - WAIT captures the final read byte, then goes to RESP.
  - RESP pulses resp_valid for one cycle, then returns to IDLE.
- Byte count N, with a = req_addr[1:0]:
  - BYTE: N=1. HALF: N=2. WORD: N=4.
  - WORDL: N=4-a. WORDR: N=a+1.
- Byte index i runs 0..N-1; mem_addr = req_addr+i, wrapping.
- Stores, one byte per XFER cycle with mem_we=1:
  - BYTE/HALF/WORD: byte i = wdata[8i+7:8i].
  - SWL: byte i = wdata[8(a+i)+7:8(a+i)].
  - SWR: byte i = wdata[8i+7:8i].
- Loads: mem_re=1 for N XFER cycles; the byte for index i is captured one cycle after its issue. Result:
  - BYTE: b0 extended per req_unsigned.
  - HALF: {b1,b0} extended per req_unsigned.
  - WORD: {b3,b2,b1,b0}.
  - LWL: bits[8(a+i)+7:8(a+i)] = b_i; the low a bytes come from req_rt.
  - LWR: bits[8i+7:8i] = b_i for i<=a; the upper 3-a bytes come from req_rt.
- Timing (accept edge = cycle 0):
  - Store: mem_we in cycles 1..N; resp_valid in cycle N+1.
  - Load: mem_re in cycles 1..N; resp_valid and resp_rdata in cycle N+2.
  - req_ready returns to 1 in the cycle after resp_valid.
- req_type 5..7: no RAM access. resp_valid in cycle 1. For loads resp_rdata=0.
- mem_re and mem_we are never asserted together.
- mem_re and mem_we are 0 outside XFER.

Test Plan:
- Preload RAM[0x10..0x13] = 11,22,33,84. WORD load at 0x10 -> mem_re cycles 1-4 with addresses 0x10..0x13; resp_valid in cycle 6 with resp_rdata = 0x84332211.
- HALF load at 0x12: signed -> 0xFFFF8433; unsigned -> 0x00008433. BYTE signed load at 0x13 -> 0xFFFFFF84.
- rt = 0xAABBCCDD: LWL at 0x11 -> 3 reads, result 0x843322DD. LWR at 0x11 -> 2 reads, result 0xAABB3322.
- wdata = 0xDEADBEEF: SWL at 0x22 -> RAM[0x22]=AD, RAM[0x23]=DE, resp in cycle 3. SWR at 0x21 -> RAM[0x21]=EF, RAM[0x22]=BE.
- WORD store 0x04030201 at 0x3FE -> writes 0x3FE=01, 0x3FF=02, 0x000=03, 0x001=04 (address wrap).
- Assert rst in cycle 2 of a WORD load -> next cycle mem_re=0, req_ready=1, no resp_valid. A back-to-back request issued in the cycle after resp_valid is accepted.
